sprite_fetch: RTL and testbench

//  Sprite pattern fetch stage between secondary-OAM evaluator (SpriteRAM) and 8-slot sprite shifter (SpriteSet).

---
 rtl/ppu_pkg.sv | 33 +++
 rtl/spr_pattern_addr.sv | 32 +++
 rtl/sprite_fetch.sv | 141 ++++++++++++++
 tb/tb_sprite_fetch.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared constants, types and helpers for the PPU sprite fetch stage.
//   SPR_FETCH_START  first dot of the 64-dot sprite pattern fetch window
//   SPR_REC_W        width of one record pushed into the sprite shifter
//   ATTR_*           bit positions inside the OAM attribute byte
//   load_field_e     bit index of each field enable in the shifter load vector
//   bitrev8          mirrors a pattern byte so the leftmost pixel lands in bit 0
package ppu_pkg;

    localparam logic [8:0]  SPR_FETCH_START = 9'd256;
    localparam int unsigned SPR_REC_W       = 27;
    localparam int unsigned LOAD_W          = 4;

    localparam int unsigned ATTR_VFLIP = 7;
    localparam int unsigned ATTR_HFLIP = 6;
    localparam int unsigned ATTR_PRIO  = 5;

    // Field enables as seen by SpriteSet: {pix1, pix2, x, attr}
    typedef enum logic [1:0] {
        LdAttr = 2'd0,
        LdX    = 2'd1,
        LdPix2 = 2'd2,
        LdPix1 = 2'd3
    } load_field_e;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/spr_pattern_addr.sv
// spr_pattern_addr: combinational sprite pattern address generator.
//   tile       in   8   tile index from secondary OAM
//   ybyte_row  in   4   low nibble of the sprite-relative Y byte
//   vflip      in   1   vertical flip attribute
//   obj_size   in   1   1 = 8x16 sprites
//   obj_patt   in   1   pattern table select for 8x8 sprites
//   plane      in   1   bit plane (0 = low byte, 1 = high byte)
//   addr       out  14  VRAM pattern address
module spr_pattern_addr (
    input  logic [7:0]  tile,
    input  logic [3:0]  ybyte_row,
    input  logic        vflip,
    input  logic        obj_size,
    input  logic        obj_patt,
    input  logic        plane,
    output logic [13:0] addr
);

    logic [3:0] row;

    always_comb begin
        // 8x16 flips across both tiles, 8x8 only within the single tile
        row = ybyte_row ^ (vflip ? (obj_size ? 4'hF : 4'h7) : 4'h0);
        if (obj_size) begin
            // Tile bit 0 picks the table; row bit 3 picks top/bottom tile
            addr = {1'b0, tile[0], tile[7:1], row[3], plane, row[2:0]};
        end else begin
            addr = {1'b0, obj_patt, tile, plane, row[2:0]};
        end
    end

endmodule

// File: rtl/sprite_fetch.sv
// sprite_fetch: sprite pattern fetch stage between the secondary-OAM evaluator
// and the 8-slot sprite shifter. In the fetch window each 8-dot slot reads one
// secondary-OAM record, fetches two pattern bytes and pushes one record.
//   clk           in   1   system clock
//   i_rst         in   1   asynchronous active-low reset
//   i_ce          in   1   dot enable
//   i_sprites_en  in   1   sprite rendering enable
//   i_obj_size    in   1   1 = 8x16 sprites
//   i_obj_patt    in   1   8x8 pattern table select
//   i_cycle       in   9   current dot
//   i_oam_bus     in   8   secondary-OAM byte
//   i_vram_data   in   8   VRAM read data (one i_ce after address)
//   o_vram_addr   out  14  pattern address (0 when not reading)
//   o_vram_rd     out  1   pattern read strobe
//   o_load        out  4   shifter field enables {pix1, pix2, x, attr}
//   o_load_in     out  27  {pix_lo, pix_hi, x, pal[1:0], prio}
module sprite_fetch
    import ppu_pkg::*;
#(
    parameter logic [8:0] FETCH_START = SPR_FETCH_START
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_ce,
    input  logic                 i_sprites_en,
    input  logic                 i_obj_size,
    input  logic                 i_obj_patt,
    input  logic [8:0]           i_cycle,
    input  logic [7:0]           i_oam_bus,
    input  logic [7:0]           i_vram_data,
    output logic [13:0]          o_vram_addr,
    output logic                 o_vram_rd,
    output logic [LOAD_W-1:0]    o_load,
    output logic [SPR_REC_W-1:0] o_load_in
);

    logic                 in_win;
    logic [2:0]           off;
    logic [7:0]           ybyte_q;
    logic [7:0]           tile_q;
    logic [7:0]           attr_q;
    logic [7:0]           xpos_q;
    logic [7:0]           pix_lo_q;
    logic                 slot_ok_q;
    logic [LOAD_W-1:0]    load_q;
    logic [SPR_REC_W-1:0] load_in_q;
    logic [LOAD_W-1:0]    load_all;
    logic [13:0]          pat_addr;
    logic                 valid;
    logic [7:0]           pix_lo_out;
    logic [7:0]           pix_hi_out;
    logic                 unused_attr;

    assign in_win = i_sprites_en && (i_cycle >= FETCH_START) &&
                    (i_cycle <= FETCH_START + 9'd63);
    assign off    = i_cycle[2:0];
    // Empty secondary-OAM slots read back as 0xFF, which fails this test
    assign valid  = (ybyte_q[7:4] == 4'h0);

    assign unused_attr = ^attr_q[4:2];

    always_comb begin
        load_all         = '0;
        load_all[LdPix1] = 1'b1;
        load_all[LdPix2] = 1'b1;
        load_all[LdX]    = 1'b1;
        load_all[LdAttr] = 1'b1;
    end

    spr_pattern_addr u_addr (
        .tile      (tile_q),
        .ybyte_row (ybyte_q[3:0]),
        .vflip     (attr_q[ATTR_VFLIP]),
        .obj_size  (i_obj_size),
        .obj_patt  (i_obj_patt),
        .plane     (off[1]),
        .addr      (pat_addr)
    );

    // Strobe is gated by reset so an asserted reset silences the bus at once
    assign o_vram_rd   = i_rst && in_win && off[2];
    assign o_vram_addr = o_vram_rd ? pat_addr : 14'd0;

    // Shifter expects leftmost pixel in bit 0 unless the sprite is h-flipped
    always_comb begin
        pix_lo_out = 8'h00;
        pix_hi_out = 8'h00;
        if (valid) begin
            if (attr_q[ATTR_HFLIP]) begin
                pix_lo_out = pix_lo_q;
                pix_hi_out = i_vram_data;
            end else begin
                pix_lo_out = bitrev8(pix_lo_q);
                pix_hi_out = bitrev8(i_vram_data);
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            ybyte_q   <= 8'h00;
            tile_q    <= 8'h00;
            attr_q    <= 8'h00;
            xpos_q    <= 8'h00;
            pix_lo_q  <= 8'h00;
            slot_ok_q <= 1'b0;
            load_q    <= '0;
            load_in_q <= '0;
        end else if (i_ce) begin
            load_q    <= '0;
            load_in_q <= '0;
            if (!in_win) begin
                // Leaving the window or disabling aborts the slot in progress
                slot_ok_q <= 1'b0;
            end else begin
                case (off)
                    3'd0: begin
                        ybyte_q   <= i_oam_bus;
                        slot_ok_q <= 1'b1;
                    end
                    3'd1: tile_q   <= i_oam_bus;
                    3'd2: attr_q   <= i_oam_bus;
                    3'd3: xpos_q   <= i_oam_bus;
                    3'd5: pix_lo_q <= i_vram_data;
                    3'd7: begin
                        if (slot_ok_q) begin
                            load_q    <= load_all;
                            load_in_q <= {pix_lo_out, pix_hi_out, xpos_q,
                                          attr_q[1:0], attr_q[ATTR_PRIO]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_load    = load_q;
    assign o_load_in = load_in_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// tb_sprite_fetch: self-checking bench for sprite_fetch. Each line of dots
// 248..327 is driven with secondary-OAM records and a VRAM model; a slot-level
// reference predicts strobes, addresses and pushed records.
module tb_sprite_fetch;

    logic        clk = 1'b0;
    logic        i_rst, i_ce, i_sprites_en, i_obj_size, i_obj_patt;
    logic [8:0]  i_cycle;
    logic [7:0]  i_oam_bus, i_vram_data;
    logic [13:0] o_vram_addr;
    logic        o_vram_rd;
    logic [3:0]  o_load;
    logic [26:0] o_load_in;

    always #5 clk = ~clk;

    sprite_fetch dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_ce         (i_ce),
        .i_sprites_en (i_sprites_en),
        .i_obj_size   (i_obj_size),
        .i_obj_patt   (i_obj_patt),
        .i_cycle      (i_cycle),
        .i_oam_bus    (i_oam_bus),
        .i_vram_data  (i_vram_data),
        .o_vram_addr  (o_vram_addr),
        .o_vram_rd    (o_vram_rd),
        .o_load       (o_load),
        .o_load_in    (o_load_in)
    );

    logic [7:0]  vram [16384];
    logic [7:0]  ry [8];
    logic [7:0]  rt [8];
    logic [7:0]  ra [8];
    logic [7:0]  rx [8];
    int          errors = 0;
    int          checks = 0;
    int          cnt [8];
    logic [3:0]  exp_load = 4'h0;
    logic [26:0] exp_rec = '0;
    int          dut_pushes;
    int          rd_hits;
    bit          dut_slot_pushed [8];
    logic [26:0] dut_rec [8];
    int          dut_rec_dot [8];
    logic [13:0] seen_lo [8];
    logic [13:0] seen_hi [8];

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Pattern address from the sprite's row within its tile(s)
    function automatic logic [13:0] model_addr(input logic [7:0] y, input logic [7:0] t,
                                               input logic [7:0] a, input logic size,
                                               input logic patt, input logic plane);
        int r, base;
        r = int'(y) % 16;
        if (a[7]) r = size ? 15 - r : (r / 8) * 8 + (7 - r % 8);
        if (size) base = (int'(t) % 2) * 4096 + (int'(t) / 2) * 32 + (r / 8) * 16;
        else      base = int'(patt) * 4096 + int'(t) * 16;
        return 14'(base + int'(plane) * 8 + r % 8);
    endfunction

    function automatic logic [26:0] model_rec(input int s, input logic size, input logic patt);
        logic [7:0] lo, hi;
        lo = vram[model_addr(ry[s], rt[s], ra[s], size, patt, 1'b0)];
        hi = vram[model_addr(ry[s], rt[s], ra[s], size, patt, 1'b1)];
        if (ry[s] >= 8'h10) begin
            lo = 8'h00;
            hi = 8'h00;
        end else if (!ra[s][6]) begin
            lo = rev8(lo);
            hi = rev8(hi);
        end
        return {lo, hi, rx[s], ra[s][1:0], ra[s][5]};
    endfunction

    function automatic logic [7:0] oam_byte(input int s, input int off);
        case (off)
            0:       return ry[s];
            1:       return rt[s];
            2:       return ra[s];
            default: return rx[s];
        endcase
    endfunction

    task automatic set_random_records();
        for (int s = 0; s < 8; s++) begin
            case ($urandom_range(0, 3))
                0:       ry[s] = 8'hFF;
                1:       ry[s] = 8'($urandom_range(16, 254));
                default: ry[s] = 8'($urandom_range(0, 15));
            endcase
            rt[s] = (ry[s] == 8'hFF) ? 8'hFF : 8'($urandom);
            ra[s] = (ry[s] == 8'hFF) ? 8'hFF : 8'($urandom);
            rx[s] = (ry[s] == 8'hFF) ? 8'hFF : 8'($urandom);
        end
    endtask

    // Drive one line. Sprites disabled for dots [en_from, en_to]; optional async
    // reset pulse inside dot rst_dot; i_ce held low stall_len clocks at stall_dot.
    task automatic run_line(input int en_from, input int en_to, input int rst_dot,
                            input int stall_dot, input int stall_len, input bit rnd_stall);
        int          stalls_left, tries, s, off, ds;
        bit          rst_done, ce_v, en_v, win, exp_rd;
        logic [13:0] addr_pre, want_addr;
        stalls_left = stall_len;
        rst_done    = 1'b0;
        dut_pushes  = 0;
        rd_hits     = 0;
        for (int i = 0; i < 8; i++) begin
            cnt[i] = 0;
            dut_slot_pushed[i] = 1'b0;
            dut_rec_dot[i] = -1;
        end
        for (int cyc = 248; cyc < 328; cyc++) begin
            ce_v  = 1'b0;
            tries = 0;
            while (!ce_v) begin
                if (cyc == stall_dot && stalls_left > 0) begin
                    stalls_left--;
                end else if (rnd_stall && tries < 3 && $urandom_range(0, 4) == 0) begin
                    tries++;
                end else begin
                    ce_v = 1'b1;
                end
                en_v = !(cyc >= en_from && cyc <= en_to);
                win  = en_v && cyc >= 256 && cyc <= 319;
                s    = (cyc >= 256 && cyc <= 319) ? (cyc - 256) / 8 : 0;
                off  = cyc % 8;
                i_ce = ce_v;
                i_cycle = 9'(cyc);
                i_sprites_en = en_v;
                if (cyc >= 256 && cyc <= 319) i_oam_bus = oam_byte(s, off);
                else                          i_oam_bus = 8'($urandom);
                #1;
                addr_pre = o_vram_addr;
                exp_rd = win && off >= 4;
                checks++;
                if (o_vram_rd !== exp_rd) begin
                    errors++;
                    $display("FAIL vram_rd dot %0d: got %b want %b", cyc, o_vram_rd, exp_rd);
                end
                if (o_vram_rd === 1'b1) rd_hits++;
                if (exp_rd) begin
                    if (off == 4) seen_lo[s] = o_vram_addr;
                    if (off == 6) seen_hi[s] = o_vram_addr;
                    if (cnt[s] == off) begin
                        want_addr = model_addr(ry[s], rt[s], ra[s], i_obj_size, i_obj_patt,
                                               1'(off / 2 % 2));
                        checks++;
                        if (o_vram_addr !== want_addr) begin
                            errors++;
                            $display("FAIL vram_addr dot %0d: got %h want %h",
                                     cyc, o_vram_addr, want_addr);
                        end
                    end
                end else begin
                    checks++;
                    if (o_vram_addr !== 14'd0) begin
                        errors++;
                        $display("FAIL vram_addr_idle dot %0d: got %h want 0000",
                                 cyc, o_vram_addr);
                    end
                end
                if (cyc == rst_dot && !rst_done) begin
                    rst_done = 1'b1;
                    #1 i_rst = 1'b0;
                    #1;
                    checks++;
                    if ({o_load, o_load_in, o_vram_rd, o_vram_addr} !== '0) begin
                        errors++;
                        $display("FAIL async_reset dot %0d: got load=%h in=%h rd=%b addr=%h want 0",
                                 cyc, o_load, o_load_in, o_vram_rd, o_vram_addr);
                    end
                    i_rst = 1'b1;
                    for (int i = 0; i < 8; i++) cnt[i] = 0;
                    exp_load = 4'h0;
                end
                @(posedge clk);
                #1;
                if (ce_v) begin
                    i_vram_data = vram[addr_pre];
                    if (win) cnt[s] = (off == 0) ? 1 : cnt[s] + 1;
                    if (win && off == 7 && cnt[s] == 8) begin
                        exp_load = 4'hF;
                        exp_rec  = model_rec(s, i_obj_size, i_obj_patt);
                    end else begin
                        exp_load = 4'h0;
                    end
                end
                checks++;
                if (o_load !== exp_load) begin
                    errors++;
                    $display("FAIL load dot %0d: got %h want %h", cyc, o_load, exp_load);
                end
                if (exp_load == 4'hF) begin
                    checks++;
                    if (o_load_in !== exp_rec) begin
                        errors++;
                        $display("FAIL load_in dot %0d: got %h want %h", cyc, o_load_in, exp_rec);
                    end
                end
                if (ce_v && o_load === 4'hF) begin
                    dut_pushes++;
                    if (cyc >= 256 && cyc <= 319) begin
                        ds = (cyc - 256) / 8;
                        dut_slot_pushed[ds] = 1'b1;
                        dut_rec[ds] = o_load_in;
                        dut_rec_dot[ds] = cyc + 1;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        i_ce = 1'b1;
        i_sprites_en = 1'b1;
        i_obj_size = 1'b0;
        i_obj_patt = 1'b1;
        i_cycle = 9'd260;
        i_oam_bus = 8'h00;
        i_vram_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (o_load !== 4'h0) begin
            errors++;
            $display("FAIL reset_load: got %h want 0", o_load);
        end
        checks++;
        if (o_load_in !== 27'h0) begin
            errors++;
            $display("FAIL reset_load_in: got %h want 0", o_load_in);
        end
        checks++;
        if (o_vram_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd: got %b want 0", o_vram_rd);
        end
        checks++;
        if (o_vram_addr !== 14'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h want 0", o_vram_addr);
        end
        i_cycle = 9'd200;
        #3 i_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [26:0] want;
        set_random_records();
        ry[0] = 8'h03; rt[0] = 8'h42; ra[0] = 8'h00; rx[0] = 8'h10;
        i_obj_size = 1'b0;
        i_obj_patt = 1'b1;
        vram[14'h1423] = 8'h80;
        vram[14'h142B] = 8'h01;
        want = {8'h01, 8'h80, 8'h10, 2'b00, 1'b0};
        run_line(999, 999, -1, -1, 0, 1'b0);
        checks++;
        if (seen_lo[0] !== 14'h1423) begin
            errors++;
            $display("FAIL basic_lo_addr: got %h want 1423", seen_lo[0]);
        end
        checks++;
        if (seen_hi[0] !== 14'h142B) begin
            errors++;
            $display("FAIL basic_hi_addr: got %h want 142b", seen_hi[0]);
        end
        checks++;
        if (dut_rec[0] !== want) begin
            errors++;
            $display("FAIL basic_record: got %h want %h", dut_rec[0], want);
        end
        checks++;
        if (dut_rec_dot[0] != 264) begin
            errors++;
            $display("FAIL basic_push_dot: got %0d want 264", dut_rec_dot[0]);
        end
    endtask

    task automatic test_flip();
        logic [26:0] want;
        set_random_records();
        ry[0] = 8'h03; rt[0] = 8'h42; ra[0] = 8'hC3; rx[0] = 8'h10;
        i_obj_size = 1'b0;
        i_obj_patt = 1'b1;
        vram[14'h1424] = 8'h80;
        vram[14'h142C] = 8'h01;
        want = {8'h80, 8'h01, 8'h10, 2'b11, 1'b0};
        run_line(999, 999, -1, -1, 0, 1'b0);
        checks++;
        if (seen_lo[0] !== 14'h1424) begin
            errors++;
            $display("FAIL flip_lo_addr: got %h want 1424", seen_lo[0]);
        end
        checks++;
        if (dut_rec[0][2:0] !== 3'b110) begin
            errors++;
            $display("FAIL flip_attr_bits: got %b want 110", dut_rec[0][2:0]);
        end
        checks++;
        if (dut_rec[0] !== want) begin
            errors++;
            $display("FAIL flip_record: got %h want %h", dut_rec[0], want);
        end
    endtask

    task automatic test_tall();
        set_random_records();
        ry[0] = 8'h0A; rt[0] = 8'h43; ra[0] = 8'h80; rx[0] = 8'h20;
        i_obj_size = 1'b1;
        i_obj_patt = 1'b0;
        run_line(999, 999, -1, -1, 0, 1'b0);
        checks++;
        if (seen_lo[0] !== 14'h1425) begin
            errors++;
            $display("FAIL tall_lo_addr: got %h want 1425", seen_lo[0]);
        end
        checks++;
        if (seen_hi[0] !== 14'h142D) begin
            errors++;
            $display("FAIL tall_hi_addr: got %h want 142d", seen_hi[0]);
        end
    endtask

    task automatic test_empty();
        logic [26:0] want;
        set_random_records();
        for (int s = 0; s < 2; s++) ry[s] = 8'($urandom_range(0, 15));
        for (int s = 2; s < 8; s++) begin
            ry[s] = 8'hFF; rt[s] = 8'hFF; ra[s] = 8'hFF; rx[s] = 8'hFF;
        end
        i_obj_size = 1'b0;
        i_obj_patt = 1'b0;
        want = {16'h0000, 8'hFF, 2'b11, 1'b1};
        run_line(999, 999, -1, -1, 0, 1'b0);
        checks++;
        if (dut_pushes != 8) begin
            errors++;
            $display("FAIL empty_push_count: got %0d want 8", dut_pushes);
        end
        checks++;
        if (dut_rec_dot[7] != 320) begin
            errors++;
            $display("FAIL empty_last_dot: got %0d want 320", dut_rec_dot[7]);
        end
        for (int s = 2; s < 8; s++) begin
            checks++;
            if (dut_rec[s] !== want) begin
                errors++;
                $display("FAIL empty_record slot %0d: got %h want %h", s, dut_rec[s], want);
            end
        end
    endtask

    task automatic test_disabled();
        set_random_records();
        i_obj_size = 1'b0;
        i_obj_patt = 1'b1;
        run_line(0, 999, -1, -1, 0, 1'b0);
        checks++;
        if (dut_pushes != 0) begin
            errors++;
            $display("FAIL disabled_pushes: got %0d want 0", dut_pushes);
        end
        checks++;
        if (rd_hits != 0) begin
            errors++;
            $display("FAIL disabled_reads: got %0d want 0", rd_hits);
        end
        run_line(270, 274, -1, -1, 0, 1'b0);
        checks++;
        if (dut_slot_pushed[1] !== 1'b0) begin
            errors++;
            $display("FAIL drop_slot1: got pushed want none");
        end
        checks++;
        if (dut_slot_pushed[0] !== 1'b1) begin
            errors++;
            $display("FAIL drop_slot0: got none want pushed");
        end
        checks++;
        if (dut_pushes != 6) begin
            errors++;
            $display("FAIL drop_push_count: got %0d want 6", dut_pushes);
        end
    endtask

    task automatic test_reset_mid();
        set_random_records();
        i_obj_size = 1'b0;
        i_obj_patt = 1'b0;
        run_line(999, 999, 262, -1, 0, 1'b0);
        checks++;
        if (dut_slot_pushed[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_slot0: got pushed want none");
        end
        checks++;
        if (dut_pushes != 7) begin
            errors++;
            $display("FAIL rst_mid_count: got %0d want 7", dut_pushes);
        end
    endtask

    task automatic test_stall();
        set_random_records();
        i_obj_size = 1'b1;
        i_obj_patt = 1'b0;
        run_line(999, 999, -1, 263, 3, 1'b0);
        checks++;
        if (dut_rec_dot[0] != 264) begin
            errors++;
            $display("FAIL stall_push_dot: got %0d want 264", dut_rec_dot[0]);
        end
        checks++;
        if (dut_pushes != 8) begin
            errors++;
            $display("FAIL stall_count: got %0d want 8", dut_pushes);
        end
        run_line(999, 999, -1, 264, 4, 1'b0);
        checks++;
        if (dut_pushes != 8) begin
            errors++;
            $display("FAIL hold_count: got %0d want 8", dut_pushes);
        end
    endtask

    task automatic test_random();
        int a, b;
        for (int n = 0; n < 6; n++) begin
            set_random_records();
            i_obj_size = 1'($urandom);
            i_obj_patt = 1'($urandom);
            if (n % 2 == 1) begin
                a = $urandom_range(256, 319);
                b = a + $urandom_range(0, 12);
            end else begin
                a = 999;
                b = 999;
            end
            run_line(a, b, -1, -1, 0, 1'b1);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) vram[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_flip();
        test_tall();
        test_empty();
        test_disabled();
        test_reset_mid();
        test_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
